// File: rtl/up_down_counter_param.sv
// Parametrised modulo-(MAX_VAL+1) up/down counter with enable, parallel load and registered terminal count.
// Define UDC_SATURATE_EN to clamp at 0/MAX_VAL instead of wrapping.
module up_down_counter_param #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Elaboration stops on a modulus the register cannot represent.
    generate
        if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_param
            $fatal(1, "ERROR: up_down_counter_param illegal MAX_VAL for WIDTH");
        end
    endgenerate

    logic at_top;
    logic at_bottom;

    assign at_top    = (d_out == MAX_CNT);
    assign at_bottom = (d_out == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            d_out <= (d_in > MAX_CNT) ? MAX_CNT : d_in;
            tc    <= 1'b0;
        end else if (en) begin
            if (mode) begin
                if (at_top) begin
`ifdef UDC_SATURATE_EN
                    d_out <= MAX_CNT;
`else
                    d_out <= '0;
`endif
                    tc    <= 1'b1;
                end else begin
                    d_out <= d_out + ONE;
                    tc    <= 1'b0;
                end
            end else begin
                if (at_bottom) begin
`ifdef UDC_SATURATE_EN
                    d_out <= '0;
`else
                    d_out <= MAX_CNT;
`endif
                    tc    <= 1'b1;
                end else begin
                    d_out <= d_out - ONE;
                    tc    <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule
